// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for a six-control-bit ALU, with a shift-add multiply.
module alu_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MUL_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             rsp_err
);
  localparam int IW = $clog2(MUL_BITS);
  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  typedef enum logic [2:0] {IDLE, EXEC, MUL_DBL, MUL_ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, rsp_data_q, rsp_data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic rsp_zr_q, rsp_zr_d, rsp_ng_q, rsp_ng_d, rsp_err_q, rsp_err_d;
  logic [5:0] ctl, nat_ctl;
  logic load;
  always_comb begin
    case (op_q)
      5'd0:    nat_ctl = 6'b101010;
      5'd1:    nat_ctl = 6'b111111;
      5'd2:    nat_ctl = 6'b111010;
      5'd3:    nat_ctl = 6'b001100;
      5'd4:    nat_ctl = 6'b110000;
      5'd5:    nat_ctl = 6'b001101;
      5'd6:    nat_ctl = 6'b110001;
      5'd7:    nat_ctl = 6'b001111;
      5'd8:    nat_ctl = 6'b110011;
      5'd9:    nat_ctl = 6'b011111;
      5'd10:   nat_ctl = 6'b110111;
      5'd11:   nat_ctl = 6'b001110;
      5'd12:   nat_ctl = 6'b110010;
      5'd13:   nat_ctl = 6'b000010;
      5'd14:   nat_ctl = 6'b010011;
      5'd15:   nat_ctl = 6'b000111;
      5'd16:   nat_ctl = 6'b000000;
      5'd17:   nat_ctl = 6'b010101;
      default: nat_ctl = CTL_ZERO;
    endcase
  end
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    rsp_data_d = rsp_data_q;
    rsp_zr_d   = rsp_zr_q;
    rsp_ng_d   = rsp_ng_q;
    rsp_err_d  = rsp_err_q;
    alu_x      = '0;
    alu_y      = '0;
    ctl        = CTL_ZERO;
    load       = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d  = cmd_op;
        a_d   = cmd_a;
        b_d   = cmd_b;
        acc_d = '0;
        idx_d = IW'(MUL_BITS - 1);
        state_d = cmd_op < 5'd18 ? EXEC : cmd_op == 5'd18 ? MUL_DBL : DONE;
        if (cmd_op > 5'd18) begin
          rsp_data_d = '0;
          rsp_zr_d   = 1'b1;
          rsp_ng_d   = 1'b0;
          rsp_err_d  = 1'b1;
        end
      end
      EXEC: begin
        alu_x   = a_q;
        alu_y   = b_q;
        ctl     = nat_ctl;
        load    = 1'b1;
        state_d = DONE;
      end
      // Doubling step; the index only advances once the bit's add (if any) is done.
      MUL_DBL: begin
        alu_x = acc_q;
        alu_y = acc_q;
        ctl   = CTL_ADD;
        acc_d = alu_result;
        if (b_q[idx_q]) state_d = MUL_ADD;
        else begin
          idx_d   = idx_q - 1'b1;
          load    = idx_q == '0;
          state_d = idx_q == '0 ? DONE : MUL_DBL;
        end
      end
      MUL_ADD: begin
        alu_x   = acc_q;
        alu_y   = a_q;
        ctl     = CTL_ADD;
        acc_d   = alu_result;
        idx_d   = idx_q - 1'b1;
        load    = idx_q == '0;
        state_d = idx_q == '0 ? DONE : MUL_DBL;
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      rsp_data_d = alu_result;
      rsp_zr_d   = alu_zr;
      rsp_ng_d   = alu_ng;
      rsp_err_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_zr_q   <= rsp_zr_d;
      rsp_ng_q   <= rsp_ng_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctl;
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed checks of alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [4:0] cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, rsp_valid, rsp_zr, rsp_ng, rsp_err;
  logic [15:0] alu_x, alu_y, alu_result, rsp_data;
  logic alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [15:0] xa, yb, o;
  logic [5:0] first_ctl;
  int pass_cnt = 0, total = 0;
  alu_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_result(alu_result), .alu_zr(alu_zr),
    .alu_ng(alu_ng), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_err(rsp_err)
  );
  // External combinational ALU the sequencer drives.
  always_comb begin
    xa = alu_zx ? 16'h0 : alu_x;
    xa = alu_nx ? ~xa : xa;
    yb = alu_zy ? 16'h0 : alu_y;
    yb = alu_ny ? ~yb : yb;
    o  = alu_f ? xa + yb : xa & yb;
  end
  assign alu_result = alu_no ? ~o : o;
  assign alu_zr = alu_result == 16'h0;
  assign alu_ng = alu_result[15];
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask
  function automatic logic [15:0] model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      5'd0: return 16'h0;
      5'd1: return 16'h1;
      5'd2: return 16'hFFFF;
      5'd3: return a;
      5'd4: return b;
      5'd5: return ~a;
      5'd6: return ~b;
      5'd7: return -a;
      5'd8: return -b;
      5'd9: return a + 16'd1;
      5'd10: return b + 16'd1;
      5'd11: return a - 16'd1;
      5'd12: return b - 16'd1;
      5'd13: return a + b;
      5'd14: return a - b;
      5'd15: return b - a;
      5'd16: return a & b;
      5'd17: return a | b;
      5'd18: return 16'(32'(a) * 32'(b));
      default: return 16'h0;
    endcase
  endfunction
  task automatic chk_idle_pins(input string tag);
    chk(tag, {alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, {32'h0, 6'b101010});
  endtask
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 5'($urandom);
    cmd_a = 16'($urandom);
    cmd_b = 16'($urandom);
  endtask
  task automatic collect(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
    int n = 0, busy = 0, lat;
    logic [15:0] e;
    logic [5:0] c;
    e = model(op, a, b);
    lat = op < 5'd18 ? 1 : op == 5'd18 ? 16 + $countones(b) : 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      c = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
      if (c != 6'b101010) begin
        if (busy == 0) first_ctl = c;
        busy++;
      end
      n++;
      @(negedge clk);
    end
    chk("latency", n, lat);
    if (op >= 5'd18) chk("alu_cycles", busy, lat);
    chk("rsp_data", rsp_data, e);
    chk("rsp_zr", rsp_zr, e == 16'h0);
    chk("rsp_ng", rsp_ng, e[15]);
    chk("rsp_err", rsp_err, op > 5'd18);
    chk_idle_pins("alu_idle_done");
    repeat (stall) begin
      @(negedge clk);
      chk("hold_data", {rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err}, {1'b1, e, e == 16'h0, e[15], op > 5'd18});
      chk("cmd_ready_busy", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("after_hs", {cmd_ready, rsp_valid}, 2'b10);
  endtask
  task automatic txn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
    issue(op, a, b);
    collect(op, a, b, stall);
  endtask
  initial begin
    logic [4:0] op;
    int r;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_rsp", {rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err}, 20'h0);
    chk_idle_pins("reset_alu");
    txn(5'd13, 16'h0007, 16'h0005, 0);
    chk("exec_ctl_add", first_ctl, 6'b000010);
    txn(5'd14, 16'h0005, 16'h0007, 0);
    txn(5'd16, 16'h00A0, 16'hA000, 0);
    txn(5'd18, 16'h0007, 16'h0005, 0);
    txn(5'd18, 16'h0100, 16'h0100, 0);
    txn(5'd18, 16'hFFFF, 16'hFFFF, 1);
    txn(5'd25, 16'hBEEF, 16'h1234, 0);
    // Backpressure with a second command held on the input the whole time.
    issue(5'd0, 16'h5A5A, 16'hA5A5);
    cmd_valid = 1'b1;
    cmd_op = 5'd3;
    cmd_a = 16'h1234;
    cmd_b = 16'h0F0F;
    collect(5'd0, 16'h5A5A, 16'hA5A5, 5);
    txn(5'd3, 16'h1234, 16'h0F0F, 0);
    // Reset during the 8th multiply cycle.
    issue(5'd18, 16'h0007, 16'hFFFF);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_state", {cmd_ready, rsp_valid}, 2'b10);
    chk_idle_pins("midreset_alu");
    txn(5'd3, 16'h1234, 16'h0000, 0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = r < 7 ? 5'($urandom_range(0, 17)) : r < 9 ? 5'd18 : 5'($urandom_range(19, 31));
      txn(op, 16'($urandom), 16'($urandom), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
